skein_nonce_scanner: RTL and testbench
======================================

// Module: skein_nonce_scanner
// PURPOSE
//  Sequencer and result checker wrapped around the pipelined skein512 core.
//  Drives a new nonce into the core every cycle over [nonce_base..nonce_end].
//  Delays each issued nonce by the core latency and compares the returned hash against a target.
//  Queues winning ("golden") nonces in a small FIFO with a valid/ready handshake to the host side.
// PARAMETERS
//  PIPE_LAT    8   clk cycles from core_nonce applied to matching core_hash valid; >=1
//  TGT_W       64  compared width; candidate = core_hash[511 -: TGT_W], unsigned
//  FIFO_DEPTH  4   golden-nonce FIFO entries; power of two, >=2
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      1-cycle pulse; begins scan (ignored unless IDLE)
//  stop         in   1      abort: no further nonces issued, in-flight ones still checked
//  nonce_base   in   32     first nonce, sampled on accepted start
//  nonce_end    in   32     last nonce (inclusive), sampled on accepted start
//  target       in   TGT_W  hit if candidate <= target, sampled on accepted start
//  core_nonce   out  32     nonce presented to skein512.nonce
//  core_hash    in   512    skein512.hash
//  busy         out  1      high in SCAN or DRAIN
//  done         out  1      1-cycle pulse when scan fully drained
//  found_valid  out  1      FIFO not empty
//  found_ready  in   1      pop when found_valid & found_ready
//  found_nonce  out  32     FIFO head
//  found_ovf    out  1      sticky: hit dropped because FIFO full; cleared on accepted start
// BEHAVIOUR
//  Reset: state=IDLE; core_nonce=0, busy=0, done=0, found_valid=0, found_nonce=0, found_ovf=0.
//    In-flight valid bits and FIFO pointers cleared; reset mid-scan discards everything.
//  FSM IDLE -> SCAN on start.
//    SCAN -> DRAIN after issuing nonce_end, or on stop.
//    DRAIN -> DONE when in-flight shift register holds no valid.
//    DONE -> IDLE next cycle; done=1 only in DONE.
//  SCAN: core_nonce=nonce_base in the first SCAN cycle, then +1 each cycle, mod 2^32.
//    nonce_end < nonce_base wraps through 0xFFFFFFFF -> 0.
//    base==end issues exactly one nonce.
//  In-flight tracker: PIPE_LAT-deep shift register of {vld, nonce}. Stage 0 = {SCAN, core_nonce}.
//    Output stage aligns with core_hash for that nonce.
//  Hit = out.vld & (core_hash[511 -: TGT_W] <= target_q). Pushed to FIFO the same cycle.
//    Equality counts as a hit.
//  FIFO: push when hit & !full. Hit & full -> dropped and found_ovf=1.
//    Full with simultaneous pop+push: both succeed, no drop.
//    Empty with push: found_valid rises next cycle (registered FIFO, no bypass).
//  stop in SCAN: the nonce on core_nonce that cycle is issued; none after. stop in other states ignored.
//  start in SCAN/DRAIN/DONE ignored. start and stop in the same IDLE cycle: start wins.
//  core_nonce holds its last value outside SCAN.
// CONFIGURATION
//  SKEIN_SCAN_HITCNT_EN defined: extra port hit_count out 32.
//    Counts all hits, including dropped ones; saturates at 0xFFFFFFFF; cleared on reset and accepted start.
//  Not defined: port absent, no counter logic.
// STRUCTURE
//  skein_pkg holds:
//    widths SKEIN_STATE_W=512, SKEIN_NONCE_W=32, SKEIN_DATA_W=96
//    FSM state encoding SCAN_IDLE/SCAN_RUN/SCAN_DRAIN/SCAN_DONE
//  Sub-module skein_hit_fifo: parameterised WIDTH/DEPTH sync FIFO with push/pop/full/empty.
//  Scanner top holds the FSM, nonce counter, in-flight shift register and comparator.
// TESTING  (bench uses behavioural core model: hash = f(nonce) delayed PIPE_LAT)
//  1 base=100,end=103, target=all-1s -> nonces 100..103 in order, 4 hits, done 1 cycle after drain.
//  2 base=0xFFFFFFFE,end=1 -> issues FFFFFFFE,FFFFFFFF,0,1; exactly 4 checks.
//  3 base=10,end=29, hits on 5 nonces, found_ready=0 -> 4 queued, found_ovf=1; then pop -> 10-order preserved.
//  4 stop asserted 3 cycles into SCAN of base=0,end=1000 -> exactly 4 nonces checked, done pulses.
//  5 rst_n low mid-DRAIN with FIFO non-empty -> all outputs 0 immediately; later start works normally.
//  6 candidate==target and candidate==target+1 -> first is a hit, second is not. HITCNT_EN: hit_count=1.

Source files
------------

// File: rtl/skein_pkg.sv
// skein_pkg: shared widths and scanner FSM encoding for the skein512 nonce scanner
package skein_pkg;
  localparam int SKEIN_STATE_W = 512;
  localparam int SKEIN_NONCE_W = 32;
  localparam int SKEIN_DATA_W  = 96;
  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_RUN   = 2'd1,
    SCAN_DRAIN = 2'd2,
    SCAN_DONE  = 2'd3
  } scan_state_e;
  function automatic logic scan_busy(input scan_state_e s);
    return s == SCAN_RUN || s == SCAN_DRAIN;
  endfunction
endpackage

// File: rtl/skein_hit_fifo.sv
// skein_hit_fifo: registered sync FIFO for golden nonces, no write-to-read bypass
// Ports: clk, rst_n (async active-low), push/din write side, pop/dout read side,
//        full/empty status. A push while full succeeds only if a pop happens the same cycle.
module skein_hit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic do_pop, do_push;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = wp_q == rp_q;
  assign full    = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rp_q[AW-1:0]];
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wp_q[AW-1:0]] = din;
    wp_d = do_push ? wp_q + 1'b1 : wp_q;
    rp_d = do_pop ? rp_q + 1'b1 : rp_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      mem_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      mem_q <= mem_d;
    end
endmodule

// File: rtl/skein_nonce_scanner.sv
// skein_nonce_scanner: issues nonces to a pipelined skein512 core and queues hashes under target
// Ports: clk, rst_n (async active-low); start/stop control; nonce_base/nonce_end/target
//        sampled on accepted start; core_nonce/core_hash to the core; busy/done status;
//        found_valid/found_ready/found_nonce golden-nonce FIFO; found_ovf sticky drop flag.
// Build option SKEIN_SCAN_HITCNT_EN adds hit_count, a saturating count of every hit.
module skein_nonce_scanner
  import skein_pkg::*;
#(
  parameter int PIPE_LAT   = 8,
  parameter int TGT_W      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [SKEIN_NONCE_W-1:0] nonce_base,
  input  logic [SKEIN_NONCE_W-1:0] nonce_end,
  input  logic [TGT_W-1:0]         target,
  output logic [SKEIN_NONCE_W-1:0] core_nonce,
  input  logic [SKEIN_STATE_W-1:0] core_hash,
  output logic                     busy,
  output logic                     done,
  output logic                     found_valid,
  input  logic                     found_ready,
  output logic [SKEIN_NONCE_W-1:0] found_nonce,
`ifdef SKEIN_SCAN_HITCNT_EN
  output logic [31:0]              hit_count,
`endif
  output logic                     found_ovf
);
  scan_state_e state_q, state_d;
  logic [SKEIN_NONCE_W-1:0] nonce_q, nonce_d, end_q, end_d;
  logic [TGT_W-1:0] tgt_q, tgt_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [PIPE_LAT-1:0][SKEIN_NONCE_W-1:0] pn_q, pn_d;
  logic [PIPE_LAT:0] vld_ext;
  logic [PIPE_LAT:0][SKEIN_NONCE_W-1:0] pn_ext;
  logic ovf_q, ovf_d;
  logic start_acc, hit, fifo_full, fifo_empty, found_pop, drop;
  logic unused_hash;
  assign unused_hash = ^core_hash;
  assign start_acc   = state_q == SCAN_IDLE && start;
  // Stage 0 captures the nonce being issued; the last stage lines up with its hash.
  assign vld_ext     = {vld_q, state_q == SCAN_RUN};
  assign pn_ext      = {pn_q, nonce_q};
  assign hit         = vld_q[PIPE_LAT-1] & (core_hash[SKEIN_STATE_W-1 -: TGT_W] <= tgt_q);
  assign found_pop   = found_ready & found_valid;
  assign drop        = hit & fifo_full & ~found_pop;
  assign core_nonce  = nonce_q;
  assign busy        = scan_busy(state_q);
  assign done        = state_q == SCAN_DONE;
  assign found_valid = ~fifo_empty;
  assign found_ovf   = ovf_q;
  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    end_d   = end_q;
    tgt_d   = tgt_q;
    case (state_q)
      SCAN_IDLE:
        if (start) begin
          state_d = SCAN_RUN;
          nonce_d = nonce_base;
          end_d   = nonce_end;
          tgt_d   = target;
        end
      SCAN_RUN:
        if (nonce_q == end_q || stop) state_d = SCAN_DRAIN;
        else nonce_d = nonce_q + 1'b1;
      SCAN_DRAIN:
        if (vld_q == '0) state_d = SCAN_DONE;
      default:
        state_d = SCAN_IDLE;
    endcase
    vld_d = vld_ext[PIPE_LAT-1:0];
    pn_d  = pn_ext[PIPE_LAT-1:0];
    ovf_d = start_acc ? 1'b0 : ovf_q | drop;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= SCAN_IDLE;
      nonce_q <= '0;
      end_q   <= '0;
      tgt_q   <= '0;
      vld_q   <= '0;
      pn_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nonce_q <= nonce_d;
      end_q   <= end_d;
      tgt_q   <= tgt_d;
      vld_q   <= vld_d;
      pn_q    <= pn_d;
      ovf_q   <= ovf_d;
    end
`ifdef SKEIN_SCAN_HITCNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  assign hit_count = hit_count_q;
  always_comb
    hit_count_d = start_acc ? '0 : (hit && hit_count_q != '1) ? hit_count_q + 1'b1 : hit_count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hit_count_q <= '0;
    else hit_count_q <= hit_count_d;
`endif
  skein_hit_fifo #(
    .WIDTH(SKEIN_NONCE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (hit),
    .din  (pn_q[PIPE_LAT-1]),
    .pop  (found_pop),
    .dout (found_nonce),
    .full (fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_skein_nonce_scanner.sv
// tb_skein_nonce_scanner: scoreboard bench with a behavioural skein core (hash = f(nonce), PIPE_LAT delay)
module tb_skein_nonce_scanner;
  localparam int LAT   = 8;
  localparam int TW    = 64;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, found_ready = 1'b0;
  logic [31:0] nonce_base = '0, nonce_end = '0;
  logic [TW-1:0] target = '0;
  logic [31:0] core_nonce, found_nonce;
  logic [511:0] core_hash;
  logic busy, done, found_valid, found_ovf;
`ifdef SKEIN_SCAN_HITCNT_EN
  logic [31:0] hit_count;
`endif
  int n_chk = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pipe[LAT];
  always #5 clk = ~clk;
  skein_nonce_scanner #(.PIPE_LAT(LAT), .TGT_W(TW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .nonce_base(nonce_base), .nonce_end(nonce_end), .target(target),
    .core_nonce(core_nonce), .core_hash(core_hash), .busy(busy), .done(done),
    .found_valid(found_valid), .found_ready(found_ready), .found_nonce(found_nonce),
`ifdef SKEIN_SCAN_HITCNT_EN
    .hit_count(hit_count),
`endif
    .found_ovf(found_ovf)
  );
  // Candidate field (top 64 bits) is the nonce itself, so hit iff nonce <= target.
  function automatic logic [511:0] hash_of(input logic [31:0] n);
    return {32'h0, n, {14{n}}};
  endfunction
  always @(posedge clk) begin
    pipe[0] <= core_nonce;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_hash = hash_of(pipe[LAT-1]);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && found_valid && found_ready) begin
      if (exp_q.size() == 0) chk("extra_found", 64'(exp_q.size()), 64'd1);
      else chk("found_nonce", found_nonce, exp_q.pop_front());
    end
  task automatic run_scan(input logic [31:0] b, input logic [31:0] e, input logic [63:0] t,
                          input int stop_at, input bit rdy);
    int n_iss, hits, cyc;
    n_iss = stop_at >= 0 ? stop_at + 1 : int'(e - b) + 1;
    hits = 0;
    for (int i = 0; i < n_iss; i++)
      if ({32'h0, b + 32'(i)} <= t) begin
        hits++;
        if (rdy || hits <= DEPTH) exp_q.push_back(b + 32'(i));
      end
    found_ready = rdy;
    nonce_base = b;
    nonce_end = e;
    target = t;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nonce_base = ~b;
    chk("first_nonce", core_nonce, b);
    chk("busy_scan", busy, 1);
    if (stop_at >= 0) begin
      for (int c = 1; c <= stop_at; c++) begin
        @(posedge clk);
        #1;
      end
      chk("stop_nonce", core_nonce, b + 32'(stop_at));
      stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
    else begin
      chk("done_ovf", found_ovf, 64'(!rdy && hits > DEPTH));
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
      if (rdy) chk("sb_empty", 64'(exp_q.size()), 0);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_nonce", core_nonce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", found_valid, 0);
    chk("rst_found", found_nonce, 0);
    chk("rst_ovf", found_ovf, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_scan(32'd100, 32'd103, '1, -1, 1'b1);
    run_scan(32'hFFFFFFFE, 32'd1, '1, -1, 1'b1);
    run_scan(32'd10, 32'd29, 64'd14, -1, 1'b0);
    chk("ovf_valid", found_valid, 1);
    chk("ovf_head", found_nonce, 10);
    found_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("ovf_sb_empty", 64'(exp_q.size()), 0);
    chk("ovf_drained", found_valid, 0);
    chk("ovf_sticky", found_ovf, 1);
    @(posedge clk);
    #1;
    run_scan(32'd0, 32'd1000, '1, 3, 1'b1);
    run_scan(32'd50, 32'd51, 64'd50, -1, 1'b1);
`ifdef SKEIN_SCAN_HITCNT_EN
    chk("hit_count", hit_count, 1);
`endif
    found_ready = 1'b0;
    nonce_base = 32'd200;
    nonce_end = 32'd203;
    target = '1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", found_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_nonce", core_nonce, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", found_valid, 0);
    chk("mid_rst_found", found_nonce, 0);
    chk("mid_rst_ovf", found_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_scan(32'd300, 32'd305, '1, -1, 1'b1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
